// File: rtl/wasca_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCI RAM arbiter: round-robin between a JTAG command slot and the Avalon
// debug_mem_slave, with an IDLE/ISSUE/RDATA access sequencer.
module wasca_nios2_gen2_0_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic              jtag_done,
    output logic              jtag_overflow,
    output logic [DATA_W-1:0] mon_dreg,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

    state_t            state, state_nx;
    logic              pend, pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    logic              last_grant_jtag;
    logic              cur_jtag, cur_wr;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    logic completing, av_cmd, av_done, jtag_cmpl;
    logic eval, j_want, av_want, grant, win_jtag;

    assign completing = (state == ISSUE && cur_wr) || state == RDATA;
    assign av_cmd     = av_read | av_write;
    assign av_done    = completing && !cur_jtag;
    assign jtag_cmpl  = completing && cur_jtag;

    // Arbitration happens when the RAM becomes free next cycle.
    assign eval     = state == IDLE || completing;
    assign j_want   = pend | jtag_req;
    assign av_want  = av_cmd & ~av_done;
    assign grant    = eval & (j_want | av_want);
    assign win_jtag = j_want & (~av_want | ~last_grant_jtag);

    always_comb begin
        state_nx = IDLE;
        unique case (state)
            IDLE:    if (grant) state_nx = ISSUE;
            ISSUE:   if (!cur_wr) state_nx = RDATA;
                     else if (grant) state_nx = ISSUE;
            RDATA:   if (grant) state_nx = ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    assign ram_we         = state == ISSUE && cur_wr;
    assign ram_re         = state == ISSUE && !cur_wr;
    assign ram_addr       = (state == ISSUE) ? cur_addr : '0;
    assign ram_wdata      = ram_we ? cur_wdata : '0;
    assign av_waitrequest = av_cmd & ~av_done;
    assign av_readdata    = (state == RDATA) ? ram_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pend            <= 1'b0;
            pend_wr         <= 1'b0;
            pend_addr       <= '0;
            pend_wdata      <= '0;
            last_grant_jtag <= 1'b0;
            cur_jtag        <= 1'b0;
            cur_wr          <= 1'b0;
            cur_addr        <= '0;
            cur_wdata       <= '0;
            jtag_done       <= 1'b0;
            jtag_overflow   <= 1'b0;
            mon_dreg        <= '0;
        end else begin
            state     <= state_nx;
            jtag_done <= jtag_cmpl;
            if (jtag_cmpl && !cur_wr)
                mon_dreg <= ram_rdata;
            if (grant) begin
                last_grant_jtag <= win_jtag;
                cur_jtag        <= win_jtag;
                if (win_jtag) begin
                    cur_wr    <= pend ? pend_wr : jtag_wr;
                    cur_addr  <= pend ? pend_addr : jtag_addr;
                    cur_wdata <= pend ? pend_wdata : jtag_wdata;
                end else begin
                    cur_wr    <= av_write;
                    cur_addr  <= av_address;
                    cur_wdata <= av_writedata;
                end
            end
            // A granted slot frees up and may take a same-cycle request.
            if (grant && win_jtag) begin
                pend <= pend & jtag_req;
                if (pend && jtag_req) begin
                    pend_wr    <= jtag_wr;
                    pend_addr  <= jtag_addr;
                    pend_wdata <= jtag_wdata;
                end
            end else if (jtag_req) begin
                if (pend) begin
                    jtag_overflow <= 1'b1;
                end else begin
                    pend       <= 1'b1;
                    pend_wr    <= jtag_wr;
                    pend_addr  <= jtag_addr;
                    pend_wdata <= jtag_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_wasca_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_wasca_nios2_gen2_0_cpu_ocimem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          jtag_req = 0, jtag_wr = 0;
    logic [AW-1:0] jtag_addr = '0;
    logic [DW-1:0] jtag_wdata = '0;
    logic          jtag_done, jtag_overflow;
    logic [DW-1:0] mon_dreg;
    logic [AW-1:0] av_address = '0;
    logic          av_read = 0, av_write = 0;
    logic [DW-1:0] av_writedata = '0;
    logic          av_waitrequest;
    logic [DW-1:0] av_readdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    wasca_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr),
        .jtag_wdata(jtag_wdata), .jtag_done(jtag_done),
        .jtag_overflow(jtag_overflow), .mon_dreg(mon_dreg),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_re(ram_re), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 32'h12345678;
        return (i * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    // Bench-side single-port RAM with one-cycle read latency
    logic          init_en = 1'b1;
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, got, exp, $time);
        end
    endtask

    // Transaction-level model
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t          slot_q[$];
    logic [DW-1:0] mm [256];
    bit            busy, op_from_jtag, op_wr, prev_jtag;
    int            op_age;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_data;
    bit            done_due, ovf;
    logic [DW-1:0] mon;
    bit            e_issue, e_finish, e_grant, e_to_jtag, av_done_seen;
    req_t          e_jin, e_avin;
    bit            e_jreq;

    task automatic model_reset();
        slot_q.delete();
        busy = 0; op_from_jtag = 0; op_wr = 0; prev_jtag = 0;
        op_age = 0; done_due = 0; ovf = 0; mon = '0;
    endtask

    task automatic model_check();
        bit avc, avw, jw;
        avc = av_read | av_write;
        e_issue  = busy && op_age == 0;
        e_finish = busy && (op_wr ? op_age == 0 : op_age == 1);
        avw = avc && !(e_finish && !op_from_jtag);
        jw  = slot_q.size() > 0 || jtag_req;
        e_grant   = (!busy || e_finish) && (avw || jw);
        e_to_jtag = jw && (!avw || !prev_jtag);
        e_jreq = jtag_req;
        e_jin  = '{jtag_wr, jtag_addr, jtag_wdata};
        e_avin = '{av_write, av_address, av_writedata};
        chk("ram_we", ram_we, e_issue && op_wr);
        chk("ram_re", ram_re, e_issue && !op_wr);
        chk("ram_addr", ram_addr, e_issue ? op_addr : '0);
        if (!(e_issue && !op_wr))
            chk("ram_wdata", ram_wdata, e_issue ? op_data : '0);
        chk("av_waitrequest", av_waitrequest,
            avc && !(e_finish && !op_from_jtag));
        if (e_finish && !op_from_jtag && !op_wr)
            chk("av_readdata", av_readdata, mm[op_addr]);
        else if (!(busy && op_age == 1))
            chk("av_readdata_idle", av_readdata, '0);
        chk("jtag_done", jtag_done, done_due);
        chk("jtag_overflow", jtag_overflow, ovf);
        chk("mon_dreg", mon_dreg, mon);
    endtask

    task automatic model_commit();
        req_t nj;
        nj = e_jin;
        av_done_seen = e_finish && !op_from_jtag;
        if (e_issue && op_wr) mm[op_addr] = op_data;
        if (e_finish && op_from_jtag && !op_wr) mon = mm[op_addr];
        done_due = e_finish && op_from_jtag;
        if (e_grant && e_to_jtag) begin
            if (slot_q.size() > 0) begin
                nj = slot_q.pop_front();
                if (e_jreq) slot_q.push_back(e_jin);
            end
        end else if (e_jreq) begin
            if (slot_q.size() > 0) ovf = 1;
            else slot_q.push_back(e_jin);
        end
        if (e_grant) begin
            busy = 1; op_age = 0;
            op_from_jtag = e_to_jtag; prev_jtag = e_to_jtag;
            if (e_to_jtag) begin
                op_wr = nj.wr; op_addr = nj.addr; op_data = nj.data;
            end else begin
                op_wr = e_avin.wr; op_addr = e_avin.addr; op_data = e_avin.data;
            end
        end else if (e_issue && !op_wr) begin
            op_age = 1;
        end else begin
            busy = 0;
        end
    endtask

    task automatic tick();
        #1 model_check();
        @(posedge clk);
        #1 model_commit();
        @(negedge clk);
    endtask

    task automatic jreq(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        jtag_req = 1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
    endtask

    task automatic av_drain();
        bit fin;
        fin = 0;
        for (int i = 0; i < 6 && !fin; i++) begin
            jtag_req = 0;
            #1 fin = !av_waitrequest;
            tick();
        end
        chk("av_drain_done", fin, 1'b1);
        av_read = 0; av_write = 0;
    endtask

    int  av_wait;
    bit  av_busy;
    int  k;

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = init_val(i);
        model_reset();
        repeat (3) @(negedge clk);
        init_en = 0;
        reset = 0;
        #1;
        chk("rst_jtag_done", jtag_done, 1'b0);
        chk("rst_overflow", jtag_overflow, 1'b0);
        chk("rst_mon_dreg", mon_dreg, '0);
        chk("rst_ram_strobes", {ram_we, ram_re}, 2'b00);
        chk("rst_ram_addr", ram_addr, '0);
        chk("rst_ram_wdata", ram_wdata, '0);
        chk("rst_waitreq", av_waitrequest, 1'b0);
        tick();

        // JTAG write then read back
        jreq(1, 8'h10, 32'hDEADBEEF);
        tick();
        jtag_req = 0;
        #1;
        chk("jw_ram_we", ram_we, 1'b1);
        chk("jw_ram_addr", ram_addr, 8'h10);
        chk("jw_ram_wdata", ram_wdata, 32'hDEADBEEF);
        tick();
        #1 chk("jw_done", jtag_done, 1'b1);
        tick();
        jreq(0, 8'h10, '0);
        tick();
        jtag_req = 0;
        #1 chk("jr_ram_re", ram_re, 1'b1);
        tick();
        tick();
        #1;
        chk("jr_mon_dreg", mon_dreg, 32'hDEADBEEF);
        chk("jr_done", jtag_done, 1'b1);
        tick();

        // Avalon read of a preloaded word
        av_read = 1; av_address = 8'h05;
        #1 chk("ar_wait0", av_waitrequest, 1'b1);
        tick();
        #1 chk("ar_wait1", av_waitrequest, 1'b1);
        tick();
        #1;
        chk("ar_wait2", av_waitrequest, 1'b0);
        chk("ar_data", av_readdata, 32'h12345678);
        tick();
        av_read = 0;
        tick();

        // Simultaneous JTAG and Avalon writes: JTAG first, no gap
        jreq(1, 8'h21, 32'hAAAA0001);
        av_write = 1; av_address = 8'h31; av_writedata = 32'hBBBB0001;
        tick();
        jtag_req = 0;
        #1;
        chk("tie_first_addr", ram_addr, 8'h21);
        chk("tie_first_wait", av_waitrequest, 1'b1);
        tick();
        #1;
        chk("tie_second_addr", ram_addr, 8'h31);
        chk("tie_second_we", ram_we, 1'b1);
        chk("tie_second_wait", av_waitrequest, 1'b0);
        tick();
        av_write = 0;
        tick();

        // Streaming Avalon writes with JTAG every other cycle
        av_write = 1; av_address = 8'h30; av_writedata = 32'h0000C0DE;
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 0) jreq(1, 8'h20, 32'h1000 + c);
            else jtag_req = 0;
            #1;
            if (c > 0) chk("alt_grant", ram_addr, (c % 2) ? 8'h20 : 8'h30);
            tick();
        end
        av_drain();
        #1 chk("alt_no_overflow", jtag_overflow, 1'b0);
        tick();

        // Make JTAG the last grantee, then overflow the slot
        jreq(1, 8'h42, 32'h42424242);
        tick();
        jtag_req = 0;
        tick();
        tick();
        av_read = 1; av_address = 8'h07;
        jreq(1, 8'h40, 32'h11111111);
        tick();
        jreq(1, 8'h41, 32'h22222222);
        tick();
        jtag_req = 0;
        #1;
        chk("ovf_av_wait", av_waitrequest, 1'b0);
        chk("ovf_av_data", av_readdata, 32'h07070707 ^ 32'hA5A50000);
        chk("ovf_flag", jtag_overflow, 1'b1);
        tick();
        av_read = 0;
        #1;
        chk("ovf_kept_addr", ram_addr, 8'h40);
        chk("ovf_kept_data", ram_wdata, 32'h11111111);
        tick();
        #1;
        chk("ovf_done", jtag_done, 1'b1);
        chk("ovf_no_second", ram_we, 1'b0);
        tick();
        #1 chk("ovf_no_second2", ram_we, 1'b0);
        tick();

        // Asynchronous reset during a write ISSUE
        jreq(1, 8'h50, 32'hCAFEF00D);
        tick();
        jtag_req = 0;
        #1 chk("rstw_we_before", ram_we, 1'b1);
        reset = 1;
        #1;
        chk("rstw_we_async", ram_we, 1'b0);
        chk("rstw_addr_async", ram_addr, '0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rstw_overflow", jtag_overflow, 1'b0);
        chk("rstw_done", jtag_done, 1'b0);
        chk("rstw_mon", mon_dreg, '0);
        chk("rstw_strobes", {ram_we, ram_re}, 2'b00);
        tick();

        // Random traffic
        av_busy = 0;
        av_wait = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!av_busy) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, 2);
                    av_read  = (k != 1);
                    av_write = (k != 0);
                    av_address = AW'($urandom_range(0, 15));
                    av_writedata = $urandom;
                    av_busy = 1;
                    av_wait = 0;
                end else begin
                    av_read = 0; av_write = 0;
                end
            end
            jtag_req = ($urandom_range(0, 3) == 0);
            jtag_wr = $urandom_range(0, 1) == 1;
            jtag_addr = AW'($urandom_range(0, 15));
            jtag_wdata = $urandom;
            tick();
            if (av_busy) begin
                av_wait++;
                if (av_done_seen) begin
                    chk("av_wait_bound", av_wait <= 5, 1'b1);
                    av_busy = 0;
                end else if (av_wait > 20) begin
                    checks++;
                    failures++;
                    $display("FAIL av_timeout: waited %0d cycles, limit 20",
                             av_wait);
                    av_busy = 0;
                end
            end
        end
        jtag_req = 0;
        if (av_busy) av_drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
